alu_arbiter: RTL and testbench

ALU_ARBITER -- requirements
Module: alu_arbiter

---
 rtl/alu_pkg.sv | 22 ++
 rtl/alu.sv | 31 +++
 rtl/alu_arbiter.sv | 99 +++++++++
 tb/tb_alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared ALU function codes and the registered response record.
package alu_pkg;

   typedef enum logic [2:0] {
      ALU_ADD = 3'b000,
      ALU_SUB = 3'b001,
      ALU_AND = 3'b010,
      ALU_OR  = 3'b011,
      ALU_XOR = 3'b100,
      ALU_SLT = 3'b101,
      ALU_SLL = 3'b110,
      ALU_SRL = 3'b111
   } alu_func_e;

   typedef struct packed {
      logic [31:0] result;
      logic        z;
      logic        n;
      logic        id;
   } alu_rsp_t;

endpackage

// File: rtl/alu.sv
// Combinational 32-bit ALU with zero and negative flags.
module alu
   import alu_pkg::*;
(
   input  logic [2:0]  func,
   input  logic [31:0] a,
   input  logic [31:0] b,
   output logic [31:0] result,
   output logic        z,
   output logic        n
);

   always_comb begin
      result = '0;
      case (alu_func_e'(func))
         ALU_ADD: result = a + b;
         ALU_SUB: result = a - b;
         ALU_AND: result = a & b;
         ALU_OR:  result = a | b;
         ALU_XOR: result = a ^ b;
         ALU_SLT: result = {31'b0, (a < b)};
         ALU_SLL: result = a << b[4:0];
         ALU_SRL: result = a >> b[4:0];
         default: result = '0;
      endcase
   end

   assign z = (result == '0);
   assign n = result[31];

endmodule

// File: rtl/alu_arbiter.sv
// Two-requester arbiter in front of one ALU with a single registered response slot.
// Define ALU_ARB_RR_EN for round-robin priority; otherwise port 0 always wins.
module alu_arbiter
   import alu_pkg::*;
(
   input  logic        clk,
   input  logic        reset_n,
   input  logic        Req0Valid,
   input  logic        Req1Valid,
   output logic        Req0Ready,
   output logic        Req1Ready,
   input  logic [31:0] Req0OpA,
   input  logic [31:0] Req0OpB,
   input  logic [31:0] Req0Imm,
   input  logic [31:0] Req1OpA,
   input  logic [31:0] Req1OpB,
   input  logic [31:0] Req1Imm,
   input  logic [2:0]  Req0Func,
   input  logic [2:0]  Req1Func,
   input  logic        Req0BSrc,
   input  logic        Req1BSrc,
   output logic        RspValid,
   input  logic        RspReady,
   output logic [31:0] RspResult,
   output logic        RspZ,
   output logic        RspN,
   output logic        RspId
);

   logic        any_valid;
   logic        accept;
   logic        grant;
   logic [2:0]  sel_func;
   logic [31:0] sel_a;
   logic [31:0] sel_b;
   logic [31:0] alu_result;
   logic        alu_z;
   logic        alu_n;
   logic        rsp_valid_q;
   alu_rsp_t    rsp_q;

   assign any_valid = Req0Valid | Req1Valid;
   // reset_n gates accept so neither Ready can rise while reset is held
   assign accept    = reset_n & (~rsp_valid_q | RspReady);

`ifdef ALU_ARB_RR_EN
   logic ptr_q;

   always_comb begin
      grant = ~Req0Valid;
      if (Req0Valid && Req1Valid)
         grant = ptr_q;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)
         ptr_q <= 1'b0;
      else if (accept && any_valid)
         ptr_q <= ~grant;
   end
`else
   assign grant = ~Req0Valid;
`endif

   assign Req0Ready = accept & any_valid & ~grant;
   assign Req1Ready = accept & any_valid &  grant;

   assign sel_func = grant ? Req1Func : Req0Func;
   assign sel_a    = grant ? Req1OpA  : Req0OpA;
   assign sel_b    = grant ? (Req1BSrc ? Req1Imm : Req1OpB)
                           : (Req0BSrc ? Req0Imm : Req0OpB);

   alu u_alu (
      .func   (sel_func),
      .a      (sel_a),
      .b      (sel_b),
      .result (alu_result),
      .z      (alu_z),
      .n      (alu_n)
   );

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         rsp_valid_q <= 1'b0;
         rsp_q       <= '0;
      end else if (accept) begin
         rsp_valid_q <= any_valid;
         if (any_valid)
            rsp_q <= '{result: alu_result, z: alu_z, n: alu_n, id: grant};
      end
   end

   assign RspValid  = rsp_valid_q;
   assign RspResult = rsp_q.result;
   assign RspZ      = rsp_q.z;
   assign RspN      = rsp_q.n;
   assign RspId     = rsp_q.id;

endmodule

// File: tb/tb_alu_arbiter.sv
// Self-checking bench for alu_arbiter: directed scenarios plus randomized traffic against a behavioural model.
module tb_alu_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic        reset_n;
   logic        rsp_ready;
   logic        r_valid [2];
   logic [2:0]  r_func  [2];
   logic [31:0] r_a     [2];
   logic [31:0] r_b     [2];
   logic [31:0] r_imm   [2];
   logic        r_bsrc  [2];

   logic        Req0Ready, Req1Ready, RspValid, RspZ, RspN, RspId;
   logic [31:0] RspResult;

   alu_arbiter dut (
      .clk       (clk),
      .reset_n   (reset_n),
      .Req0Valid (r_valid[0]),
      .Req1Valid (r_valid[1]),
      .Req0Ready (Req0Ready),
      .Req1Ready (Req1Ready),
      .Req0OpA   (r_a[0]),
      .Req0OpB   (r_b[0]),
      .Req0Imm   (r_imm[0]),
      .Req1OpA   (r_a[1]),
      .Req1OpB   (r_b[1]),
      .Req1Imm   (r_imm[1]),
      .Req0Func  (r_func[0]),
      .Req1Func  (r_func[1]),
      .Req0BSrc  (r_bsrc[0]),
      .Req1BSrc  (r_bsrc[1]),
      .RspValid  (RspValid),
      .RspReady  (rsp_ready),
      .RspResult (RspResult),
      .RspZ      (RspZ),
      .RspN      (RspN),
      .RspId     (RspId)
   );

   // Model of the response slot and the preferred port
   logic        m_valid;
   logic [31:0] m_res;
   logic        m_id;
   logic        pref;
   logic        last_acc [2];
   logic        seen_rdy [2];

   int unsigned n_checks = 0;
   int unsigned n_pass   = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act === exp)
         n_pass++;
      else
         $display("FAIL %s: got %08h expected %08h at %0t", name, act, exp, $time);
   endtask

   function automatic logic [31:0] ref_alu(input logic [2:0] f, input logic [31:0] a, input logic [31:0] b);
      case (f)
         3'd0:    return a + b;
         3'd1:    return a - b;
         3'd2:    return a & b;
         3'd3:    return a | b;
         3'd4:    return a ^ b;
         3'd5:    return (a < b) ? 32'd1 : 32'd0;
         3'd6:    return a << b[4:0];
         default: return a >> b[4:0];
      endcase
   endfunction

   function automatic logic [31:0] rnd_word();
      if ($urandom_range(0, 3) == 0)
         return 32'($urandom_range(0, 40));
      return $urandom;
   endfunction

   task automatic set_op(input int i, input logic [2:0] f, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] imm, input logic bsrc);
      r_valid[i] = 1'b1;
      r_func[i]  = f;
      r_a[i]     = a;
      r_b[i]     = b;
      r_imm[i]   = imm;
      r_bsrc[i]  = bsrc;
   endtask

   task automatic rand_op(input int i);
      set_op(i, 3'($urandom_range(0, 7)), rnd_word(), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
   endtask

   task automatic model_reset();
      m_valid = 1'b0;
      m_res   = '0;
      m_id    = 1'b0;
      pref    = 1'b0;
   endtask

   // Called #1 after a rising edge; checks at the falling edge and advances the model at the next rising edge.
   task automatic run_cycle();
      logic        acc, any, g;
      logic [31:0] bsel;
      any = r_valid[0] | r_valid[1];
      acc = !m_valid || rsp_ready;
`ifdef ALU_ARB_RR_EN
      if (r_valid[0] && r_valid[1]) g = pref;
      else                          g = !r_valid[0];
`else
      g = !r_valid[0];
`endif
      @(negedge clk);
      seen_rdy[0] = Req0Ready;
      seen_rdy[1] = Req1Ready;
      chk("req0_ready", Req0Ready, acc && r_valid[0] && !g);
      chk("req1_ready", Req1Ready, acc && r_valid[1] && g);
      chk("rsp_valid", RspValid, m_valid);
      if (m_valid) begin
         chk("rsp_result", RspResult, m_res);
         chk("rsp_z", RspZ, m_res == 0);
         chk("rsp_n", RspN, m_res[31]);
         chk("rsp_id", RspId, m_id);
      end
      @(posedge clk);
      last_acc[0] = 1'b0;
      last_acc[1] = 1'b0;
      if (acc) begin
         m_valid = any;
         if (any) begin
            bsel        = r_bsrc[g] ? r_imm[g] : r_b[g];
            m_res       = ref_alu(r_func[g], r_a[g], bsel);
            m_id        = g;
            pref        = !g;
            last_acc[g] = 1'b1;
         end
      end
      #1;
   endtask

   initial begin
      reset_n   = 1'b0;
      rsp_ready = 1'b1;
      rand_op(0);
      rand_op(1);
      model_reset();
      repeat (2) @(posedge clk);
      #1;
      chk("rst_valid", RspValid, 0);
      chk("rst_result", RspResult, 0);
      chk("rst_zni", {RspZ, RspN, RspId}, 0);
      chk("rst_ready", {Req0Ready, Req1Ready}, 0);
      r_valid[0] = 1'b0;
      r_valid[1] = 1'b0;
      reset_n    = 1'b1;

      // Both valid: XOR and SLL
      set_op(0, 3'd4, 32'hF0F0F0F0, 32'h0F0F0F0F, 32'h0, 1'b0);
      set_op(1, 3'd6, 32'h1, 32'd31, 32'h0, 1'b0);
      run_cycle();
      chk("031_res0", RspResult, 32'hFFFFFFFF);
      chk("031_n0", RspN, 1);
      chk("031_id0", RspId, 0);
      r_valid[0] = 1'b0;
      run_cycle();
      chk("031_res1", RspResult, 32'h80000000);
      chk("031_n1", RspN, 1);
      chk("031_id1", RspId, 1);
      r_valid[0] = 1'b1;
      for (int k = 0; k < 4; k++) begin
         run_cycle();
`ifdef ALU_ARB_RR_EN
         chk("031_rr_id", RspId, 32'(k % 2));
`else
         chk("031_fixed_id", RspId, 0);
`endif
      end
      r_valid[0] = 1'b0;
      r_valid[1] = 1'b0;
      run_cycle();
      chk("drain_valid", RspValid, 0);

      // ADD 5 + (-5) through the immediate path
      set_op(0, 3'd0, 32'd5, 32'h1234, 32'hFFFFFFFB, 1'b1);
      run_cycle();
      chk("030_valid", RspValid, 1);
      chk("030_res", RspResult, 0);
      chk("030_z", RspZ, 1);
      chk("030_id", RspId, 0);
      r_valid[0] = 1'b0;
      run_cycle();

      // Back-pressure with SUB 3-5
      rsp_ready = 1'b0;
      set_op(1, 3'd1, 32'd3, 32'd5, 32'h0, 1'b0);
      run_cycle();
      chk("032_res", RspResult, 32'hFFFFFFFE);
      for (int k = 0; k < 3; k++) begin
         run_cycle();
         chk("032_hold_res", RspResult, 32'hFFFFFFFE);
         chk("032_hold_ready", Req1Ready, 0);
      end
      rsp_ready = 1'b1;
      run_cycle();
      chk("032_accept", seen_rdy[1], 1);
      r_valid[1] = 1'b0;
      run_cycle();

      // Eight back-to-back unsigned compares
      for (int k = 0; k < 8; k++) begin
         if (k == 0)      set_op(0, 3'd5, 32'd1, 32'd2, 32'h0, 1'b0);
         else if (k == 1) set_op(0, 3'd5, 32'hFFFFFFFF, 32'd1, 32'h0, 1'b0);
         else             set_op(0, 3'd5, rnd_word(), rnd_word(), rnd_word(), 1'($urandom_range(0, 1)));
         run_cycle();
         chk("033_valid", RspValid, 1);
         if (k == 0) chk("033_lt", RspResult, 1);
         if (k == 1) chk("033_ge", RspResult, 0);
      end
      r_valid[0] = 1'b0;
      run_cycle();

      // Randomized traffic
      for (int c = 0; c < 400; c++) begin
         rsp_ready = ($urandom_range(0, 3) != 0);
         for (int i = 0; i < 2; i++) begin
            if (last_acc[i] || !r_valid[i]) begin
               r_valid[i] = 1'b0;
               if ($urandom_range(0, 9) < 7)
                  rand_op(i);
            end
         end
         run_cycle();
      end

      // Reset while a response is pending
      rsp_ready = 1'b0;
      rand_op(0);
      rand_op(1);
      run_cycle();
      chk("034_pending", RspValid, 1);
      #2;
      reset_n = 1'b0;
      #1;
      chk("034_valid", RspValid, 0);
      chk("034_result", RspResult, 0);
      chk("034_zni", {RspZ, RspN, RspId}, 0);
      chk("034_ready", {Req0Ready, Req1Ready}, 0);
      model_reset();
      @(posedge clk);
      #1;
      chk("034_hold", RspValid, 0);
      reset_n   = 1'b1;
      rsp_ready = 1'b1;
      run_cycle();
      chk("034_first_id", RspId, 0);
      chk("034_first_valid", RspValid, 1);
      r_valid[0] = 1'b0;
      r_valid[1] = 1'b0;
      run_cycle();

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
